// File: rtl/setassoc_icache.sv
// rtl/setassoc_icache.sv - set-associative instruction cache with AXI burst line fill
//
// Ports:
//   clock, reset                  - clock; synchronous active-high reset
//   req_valid/req_ready/req_addr  - fetch request (word-aligned byte address)
//   rsp_valid/rsp_ready/rsp_data/rsp_err - fetch response, rsp_err flags a bus error
//   flush                         - invalidate every line (acted on only while idle)
//   m_axi_ar*                     - AXI read address channel (one INCR burst per miss)
//   m_axi_r*                      - AXI read data channel
module setassoc_icache #(
    parameter int ADDR_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int SETS       = 4,
    parameter int WAYS       = 4,
    parameter int BEAT_W     = 64,
    parameter int WORD_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              flush,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [BEAT_W-1:0] m_axi_rdata,
    input  logic              m_axi_rlast,
    input  logic [1:0]        m_axi_rresp
);
    localparam int OFF_W   = $clog2(LINE_BYTES);
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_B   = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W  = LINE_BYTES * 8;
    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAY_B   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_SH = $clog2(WORD_W / 8);
    localparam int WORDS   = LINE_W / WORD_W;
    localparam int WIDX_B  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int ARLEN   = BEATS - 1;
    localparam int ARSIZE  = $clog2(BEAT_W / 8);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_FILL, S_RESP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   line_buf;
    logic [BEAT_CW-1:0]  beat_q;
    logic                err_q;

    logic                valid_q [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]   data_q  [SETS][WAYS];
    logic [WAY_B-1:0]    rr_q    [SETS];

    logic [IDX_B-1:0]    cur_idx;
    logic [TAG_W-1:0]    cur_tag;
    logic [WIDX_B-1:0]   word_idx;
    logic                hit;
    logic [WAY_B-1:0]    hit_way;
    logic [WAY_B-1:0]    victim;
    logic                found_free;
    logic [LINE_W-1:0]   fill_line;
    logic                beat_fire;
    logic                beat_bad;
    logic                unused_rlast;

    // Completion is counted by beats, so rlast carries no information here.
    assign unused_rlast = m_axi_rlast;

    generate
        if (IDX_W > 0) begin : g_idx
            assign cur_idx = addr_q[OFF_W +: IDX_W];
        end else begin : g_noidx
            assign cur_idx = '0;
        end
    endgenerate

    assign cur_tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign word_idx  = WIDX_B'(addr_q[OFF_W-1:0] >> WORD_SH);
    assign req_ready = (state == S_IDLE) && !flush;
    assign beat_fire = m_axi_rvalid && m_axi_rready;
    assign beat_bad  = (m_axi_rresp != 2'b00);

    function automatic logic [WORD_W-1:0] pick(input logic [LINE_W-1:0] line,
                                               input logic [WIDX_B-1:0] wi);
        return WORD_W'(line >> (int'(wi) * WORD_W));
    endfunction

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        found_free = 1'b0;
        victim     = rr_q[cur_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[cur_idx][w] && tag_q[cur_idx][w] == cur_tag && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_B'(w);
            end
            // An empty way always beats the round-robin choice.
            if (!valid_q[cur_idx][w] && !found_free) begin
                found_free = 1'b1;
                victim     = WAY_B'(w);
            end
        end
    end

    // Line as it looks once the beat on the bus this cycle is merged in, so the
    // final beat can be installed and forwarded in the same cycle it arrives.
    always_comb begin
        fill_line = line_buf;
        fill_line[int'(beat_q) * BEAT_W +: BEAT_W] = m_axi_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            line_buf      <= '0;
            beat_q        <= '0;
            err_q         <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
            m_axi_rready  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            rr_q[s] <= '0;
                            for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
                        end
                    end else if (req_valid) begin
                        addr_q <= req_addr;
                        state  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        rsp_data  <= pick(data_q[cur_idx][hit_way], word_idx);
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        m_axi_arlen   <= 8'(ARLEN);
                        m_axi_arsize  <= 3'(ARSIZE);
                        m_axi_arburst <= 2'b01;
                        state         <= S_AR;
                    end
                end
                S_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        beat_q        <= '0;
                        err_q         <= 1'b0;
                        state         <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (beat_fire) begin
                        line_buf <= fill_line;
                        beat_q   <= beat_q + 1'b1;
                        if (beat_bad) err_q <= 1'b1;
                        if (beat_q == BEAT_CW'(ARLEN)) begin
                            m_axi_rready <= 1'b0;
                            rsp_valid    <= 1'b1;
                            state        <= S_RESP;
                            if (err_q || beat_bad) begin
                                // A poisoned line is dropped; replacement state untouched.
                                rsp_err  <= 1'b1;
                                rsp_data <= '0;
                            end else begin
                                rsp_err                  <= 1'b0;
                                rsp_data                 <= pick(fill_line, word_idx);
                                valid_q[cur_idx][victim] <= 1'b1;
                                tag_q[cur_idx][victim]   <= cur_tag;
                                data_q[cur_idx][victim]  <= fill_line;
                                rr_q[cur_idx] <= (rr_q[cur_idx] == WAY_B'(WAYS - 1)) ?
                                                 '0 : rr_q[cur_idx] + 1'b1;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_setassoc_icache.sv
// tb/tb_setassoc_icache.sv - scoreboard bench for setassoc_icache with randomized AXI slave
module tb_setassoc_icache;
    logic        clock, reset;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        flush;
    logic        arvalid, arready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;

    setassoc_icache dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush(flush),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
        .m_axi_rlast(rlast), .m_axi_rresp(rresp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Backing memory: every word is a distinct function of its address, except
    // the one beat the cold-miss scenario pins down explicitly.
    function automatic logic [63:0] mem_beat(input logic [63:0] line, input int k);
        logic [31:0] a;
        if (line == 64'h1000 && k == 1) return 64'hBBBB_BBBB_AAAA_AAAA;
        a = line[31:0] + 32'(k * 8);
        return {~(a + 32'd4), a ^ 32'h5A00_0000};
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        logic [63:0] b;
        int wi;
        wi = int'((addr >> 2) & 64'hF);
        b  = mem_beat(addr & ~64'h3F, wi / 2);
        return (wi % 2 == 1) ? b[63:32] : b[31:0];
    endfunction

    // Reference cache state: which line tag sits in each way, and the replacement pointer.
    bit          m_valid [4][4];
    logic [63:0] m_tag   [4][4];
    int          m_rr    [4];

    task automatic model_clear();
        for (int s = 0; s < 4; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          hit;
        int          hs_cyc;
        int          ar_total;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] ar_q[$];
    int          ar_expected = 0;

    // AXI slave state
    int          err_next_beat = -1;
    int          err_cur = -1;
    bit          burst_on = 0, pend_ar = 0, pend_r = 0, slave_kill = 0;
    int          s_beat = 0;
    logic [63:0] s_line, lat_addr;
    int          ar_seen = 0;

    initial begin
        arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = '0;
        forever begin
            @(negedge clock);
            if (slave_kill) begin
                burst_on = 0; pend_ar = 0; pend_r = 0; slave_kill = 0;
            end
            if (pend_ar) begin
                burst_on = 1; s_beat = 0; s_line = lat_addr;
                err_cur = err_next_beat; err_next_beat = -1;
            end
            if (pend_r) begin
                s_beat++;
                if (s_beat == 8) burst_on = 0;
            end
            arready = (!burst_on && arvalid) ? ($urandom_range(0, 2) != 0) : 1'b0;
            if (burst_on) begin
                rvalid = ($urandom_range(0, 3) != 0);
                rdata  = mem_beat(s_line, s_beat);
                rresp  = (s_beat == err_cur) ? 2'd2 : 2'd0;
                rlast  = (s_beat == 7);
            end else begin
                rvalid = 0; rresp = '0; rlast = 0;
            end
            #1;
            pend_ar = arvalid && arready && !reset;
            pend_r  = rvalid && rready && !reset;
            if (pend_ar) begin
                lat_addr = araddr;
                ar_seen++;
                if (ar_q.size() == 0) begin
                    check(0, "ar_unexpected", araddr, 64'h0);
                end else begin
                    logic [63:0] e;
                    e = ar_q.pop_front();
                    check(araddr == e, "araddr", araddr, e);
                    check(arlen == 8'd7, "arlen", 64'(arlen), 64'd7);
                    check(arsize == 3'd3, "arsize", 64'(arsize), 64'd3);
                    check(arburst == 2'd1, "arburst", 64'(arburst), 64'd1);
                end
            end
        end
    end

    // Response ready: random, or held low for 5 cycles of a pending response.
    bit hold_mode = 0;
    int hold_cnt = 0;
    initial begin
        rsp_ready = 0;
        forever begin
            @(negedge clock);
            if (hold_mode && rsp_valid && hold_cnt < 5) begin
                rsp_ready = 0;
                hold_cnt++;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on each response handshake.
    initial begin
        bit          prev_valid, prev_stall;
        logic [31:0] held_data;
        logic        held_err;
        int          first_cyc;
        exp_t        e;
        prev_valid = 0; prev_stall = 0; held_data = '0; held_err = 0; first_cyc = 0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                prev_valid = 0; prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                check(rsp_valid == 1'b1, "rsp_valid_held", 64'(rsp_valid), 64'd1);
                check(rsp_data == held_data && rsp_err == held_err, "rsp_data_held",
                      {31'd0, rsp_err, rsp_data}, {31'd0, held_err, held_data});
            end
            if (rsp_valid && !prev_valid) first_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check(0, "rsp_unexpected", 64'(rsp_data), 64'h0);
                end else begin
                    e = sb_q.pop_front();
                    check(rsp_data == e.data, "rsp_data", 64'(rsp_data), 64'(e.data));
                    check(rsp_err == e.err, "rsp_err", 64'(rsp_err), 64'(e.err));
                    check(ar_seen == e.ar_total, "ar_count", 64'(ar_seen), 64'(e.ar_total));
                    if (e.hit)
                        check(first_cyc - e.hs_cyc == 2, "hit_latency",
                              64'(first_cyc - e.hs_cyc), 64'd2);
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            held_data  = rsp_data;
            held_err   = rsp_err;
            prev_valid = rsp_valid;
        end
    end

    // Predict the outcome, then perform the request handshake.
    task automatic issue(input logic [63:0] addr, input int inj_beat);
        int          idx, v;
        logic [63:0] tag, line;
        exp_t        e;
        bit          done;
        idx  = int'((addr >> 6) & 64'h3);
        tag  = addr >> 8;
        line = addr & ~64'h3F;
        e.hit = 0;
        for (int w = 0; w < 4; w++) if (m_valid[idx][w] && m_tag[idx][w] == tag) e.hit = 1;
        if (e.hit) begin
            e.data = mem_word(addr);
            e.err  = 0;
        end else begin
            ar_expected++;
            ar_q.push_back(line);
            if (inj_beat >= 0) begin
                err_next_beat = inj_beat;
                e.data = '0;
                e.err  = 1;
            end else begin
                e.data = mem_word(addr);
                e.err  = 0;
                v = -1;
                for (int w = 0; w < 4; w++) if (!m_valid[idx][w] && v < 0) v = w;
                if (v < 0) v = m_rr[idx];
                m_valid[idx][v] = 1;
                m_tag[idx][v]   = tag;
                m_rr[idx]       = (m_rr[idx] + 1) % 4;
            end
        end
        e.ar_total = ar_expected;
        @(negedge clock);
        req_valid = 1;
        req_addr  = addr;
        done = 0;
        for (int t = 0; t < 5000 && !done; t++) begin
            #1;
            if (req_ready) done = 1;
            else @(negedge clock);
        end
        if (!done) begin
            check(0, "req_accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 0;
            return;
        end
        e.hs_cyc = cyc;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        req_valid = 0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int t = 0; t < 5000 && !done; t++) begin
            @(negedge clock);
            #3;
            if (sb_q.size() == 0 && req_ready && !rsp_valid) done = 1;
        end
        if (!done) check(0, "idle_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_flush(input bit with_req, input logic [63:0] addr);
        wait_idle();
        @(negedge clock);
        flush     = 1;
        req_valid = with_req;
        req_addr  = addr;
        #1;
        check(req_ready == 1'b0, "flush_blocks_req", 64'(req_ready), 64'd0);
        @(posedge clock);
        #1;
        flush     = 0;
        req_valid = 0;
        model_clear();
        @(negedge clock);
        #1;
        check(req_ready == 1'b1 && !rsp_valid && !arvalid, "flush_no_accept",
              64'(req_ready), 64'd1);
    endtask

    initial begin
        bit done;
        reset = 1; flush = 0; req_valid = 0; req_addr = '0;
        model_clear();
        repeat (3) @(negedge clock);
        reset = 0;
        #1;
        check(req_ready == 1'b1, "rst_req_ready", 64'(req_ready), 64'd1);
        check(rsp_valid == 1'b0, "rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check(rsp_data == 32'd0, "rst_rsp_data", 64'(rsp_data), 64'd0);
        check(rsp_err == 1'b0, "rst_rsp_err", 64'(rsp_err), 64'd0);
        check(arvalid == 1'b0, "rst_arvalid", 64'(arvalid), 64'd0);
        check(rready == 1'b0, "rst_rready", 64'(rready), 64'd0);
        check(araddr == 64'd0, "rst_araddr", araddr, 64'd0);
        check(arlen == 8'd0, "rst_arlen", 64'(arlen), 64'd0);
        check(arsize == 3'd0, "rst_arsize", 64'(arsize), 64'd0);
        check(arburst == 2'd0, "rst_arburst", 64'(arburst), 64'd0);

        // Cold miss, then hit on the neighbouring word of the same line.
        issue(64'h1008, -1); wait_idle();
        issue(64'h100C, -1); wait_idle();

        // Flush racing a request: flush wins, the cached line is gone afterwards.
        do_flush(1, 64'h100C);
        issue(64'h100C, -1); wait_idle();

        // Replacement in set 0 from an empty cache.
        do_flush(0, 64'h0);
        issue(64'h0000, -1); wait_idle();
        issue(64'h0100, -1); wait_idle();
        issue(64'h0200, -1); wait_idle();
        issue(64'h0300, -1); wait_idle();
        issue(64'h0400, -1); wait_idle();
        issue(64'h0104, -1); wait_idle();
        issue(64'h0000, -1); wait_idle();

        // Bus error on beat 3, then a clean refetch.
        issue(64'h2008, 3); wait_idle();
        issue(64'h2008, -1); wait_idle();

        // Response backpressure for 5 cycles.
        hold_mode = 1; hold_cnt = 0;
        issue(64'h2010, -1); wait_idle();
        hold_mode = 0;

        // Randomized traffic over 24 lines competing for 16 slots.
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a;
            int inj;
            if ($urandom_range(0, 11) == 0) do_flush($urandom_range(0, 1) == 1, 64'h40);
            a = (64'($urandom_range(0, 5)) << 8) | (64'($urandom_range(0, 3)) << 6) |
                (64'($urandom_range(0, 15)) << 2);
            inj = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            issue(a, inj);
            wait_idle();
        end

        // Reset during the fill, at beat 4.
        do_flush(0, 64'h0);
        issue(64'h3000, -1);
        done = 0;
        for (int t = 0; t < 5000 && !done; t++) begin
            @(negedge clock);
            #2;
            if (burst_on && s_beat >= 4) done = 1;
        end
        if (!done) check(0, "fill_beat4_timeout", 64'(s_beat), 64'd4);
        @(negedge clock);
        reset = 1;
        slave_kill = 1;
        model_clear();
        @(negedge clock);
        reset = 0;
        sb_q.delete();
        #1;
        check(rready == 1'b0, "rst_fill_rready", 64'(rready), 64'd0);
        check(arvalid == 1'b0, "rst_fill_arvalid", 64'(arvalid), 64'd0);
        check(req_ready == 1'b1, "rst_fill_idle", 64'(req_ready), 64'd1);
        check(rsp_valid == 1'b0, "rst_fill_rsp_valid", 64'(rsp_valid), 64'd0);
        issue(64'h3000, -1); wait_idle();

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
